// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - kernel-loop sequencer: walks output windows and kernel taps
// Counters always name the tap being issued when in RUN; ia/wa are registered from their next values.
module core_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_init_i,
  input  logic        out_busy_i,
  input  logic [5:0]  iw_i,
  input  logic [5:0]  ow_i,
  input  logic [5:0]  oh_i,
  input  logic [3:0]  kw_i,
  input  logic [3:0]  kh_i,
  output logic        exec_o,
  output logic [11:0] ia_o,
  output logic [9:0]  wa_o,
  output logic        k_init_o,
  output logic        k_fin_o,
  output logic        s_fin_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  oy_q, oy_d;
  logic [5:0]  ox_q, ox_d;
  logic [3:0]  ky_q, ky_d;
  logic [3:0]  kx_q, kx_d;
  logic [11:0] ia_q, ia_d;
  logic [9:0]  wa_q, wa_d;
  logic        last_tap;
  logic        last_win;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      oy_q    <= '0;
      ox_q    <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      ia_q    <= '0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
      ia_q    <= ia_d;
      wa_q    <= wa_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    oy_d     = oy_q;
    ox_d     = ox_q;
    ky_d     = ky_q;
    kx_d     = kx_q;
    last_tap = (kx_q == kw_i) && (ky_q == kh_i);
    last_win = (ox_q == ow_i) && (oy_q == oh_i);

    case (state_q)
      S_IDLE: begin
        if (s_init_i) begin
          oy_d    = '0;
          ox_d    = '0;
          ky_d    = '0;
          kx_d    = '0;
          state_d = out_busy_i ? S_WAIT : S_RUN;
        end
      end
      S_RUN: begin
        if (!last_tap) begin
          if (kx_q == kw_i) begin
            kx_d = '0;
            ky_d = ky_q + 4'd1;
          end else begin
            kx_d = kx_q + 4'd1;
          end
        end else begin
          kx_d = '0;
          ky_d = '0;
          if (last_win) begin
            ox_d    = '0;
            oy_d    = '0;
            state_d = S_DONE;
          end else begin
            if (ox_q == ow_i) begin
              ox_d = '0;
              oy_d = oy_q + 6'd1;
            end else begin
              ox_d = ox_q + 6'd1;
            end
            // Back-pressure is only honoured here, between windows.
            if (out_busy_i) state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!out_busy_i) state_d = S_RUN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // 12-bit modular arithmetic gives the required wrap without a wider product.
    ia_d = ({6'd0, oy_d} + {8'd0, ky_d}) * ({6'd0, iw_i} + 12'd1)
         + {6'd0, ox_d} + {8'd0, kx_d};
    wa_d = {6'd0, ky_d} * ({6'd0, kw_i} + 10'd1) + {6'd0, kx_d};
  end

  assign exec_o   = (state_q == S_RUN);
  assign ia_o     = ia_q;
  assign wa_o     = wa_q;
  assign k_init_o = exec_o && (kx_q == 4'd0) && (ky_q == 4'd0);
  assign k_fin_o  = exec_o && last_tap;
  assign s_fin_o  = (state_q == S_DONE);

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Kernel-loop sequencer for the convolution core. On `s_init` from `batch_ctrl` it walks every output window and kernel tap of the current input buffer. It issues one input-buffer read address (`ia`) and one parameter read address (`wa`) per cycle, and frames each window with `k_init`/`k_fin` for `out_ctrl`. It respects `out_busy` back-pressure at window boundaries and returns `s_fin` to `batch_ctrl` when the whole map is done.

## Interface
- No parameters; widths fixed to match `batch_ctrl`/`out_ctrl` (12-bit buffer address, 10-bit parameter address).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_init` in 1: one-cycle start pulse from `batch_ctrl`.
- `out_busy` in 1: from `out_ctrl`; when 1, no new window may start.
- `iw` in 6: input width minus 1.
- `ow` in 6: output width minus 1.
- `oh` in 6: output height minus 1.
- `kw` in 4: kernel width minus 1.
- `kh` in 4: kernel height minus 1.
- `exec` out 1: `ia`/`wa` valid this cycle; one MAC step.
- `ia` out 12: input buffer read address.
- `wa` out 10: parameter read address (same for all `prm_v` lanes).
- `k_init` out 1: first tap of a window, coincident with `exec`.
- `k_fin` out 1: last tap of a window, coincident with `exec`.
- `s_fin` out 1: one-cycle pulse, whole map finished.

## Operation
- Four nested counters, outermost first: `oy` in 0..`oh`, `ox` in 0..`ow`, `ky` in 0..`kh`, `kx` in 0..`kw`.
  - `kx` increments on every `exec` cycle.
  - Each inner counter wraps to 0 at its limit and carries to the next outer counter.
- Addresses are registered outputs:
  - `ia = (oy+ky)*(iw+1) + ox + kx`, computed at full precision and truncated to 12 bits (modulo 4096, no saturation).
  - `wa = ky*(kw+1) + kx`, truncated to 10 bits.
- FSM states:
  - IDLE: `exec`=0. On `s_init` clear all counters and go to RUN. If `out_busy`=1 at that moment, go to WAIT instead.
  - RUN: `exec`=1 every cycle.
    - At the window's last tap (`kx`=`kw` and `ky`=`kh`), assert `k_fin`.
    - If it is also the last window (`ox`=`ow`, `oy`=`oh`), go to DONE.
    - Otherwise advance `ox`/`oy`. If `out_busy`=1 in that cycle, go to WAIT; else stay in RUN.
  - WAIT: `exec`=0, counters held. Leave for RUN in the first cycle `out_busy`=0.
  - DONE: `exec`=0. Pulse `s_fin` for one cycle, return to IDLE.
- `k_init` = `exec` & `kx`=0 & `ky`=0.
- `out_busy` is sampled only at window boundaries. It has no effect mid-window, in IDLE, or in DONE.
- `s_init` outside IDLE is ignored, including during DONE. It is accepted in the IDLE cycle immediately after `s_fin`.
- Single-tap kernel (`kw`=`kh`=0): `k_init` and `k_fin` are both high on the same cycle for every window.
- Configuration inputs must be stable from `s_init` until `s_fin`. They are sampled combinationally and never latched.

## Timing
- Reset values:
  - state IDLE, all counters 0.
  - `exec`, `k_init`, `k_fin`, `s_fin` = 0; `ia` = 0; `wa` = 0.
- `rst` mid-run: the next cycle is IDLE with all outputs 0. No `s_fin` and no `k_fin` are emitted for the aborted map.
- Latency:
  - `s_init` at cycle t gives the first `exec`/`k_init` at t+1 (assuming `out_busy`=0).
  - The last `k_fin` at cycle u gives `s_fin` at u+1.
  - The next `s_init` can be accepted at u+2.
- Throughput: `(oh+1)(ow+1)(kh+1)(kw+1)` `exec` cycles per map, plus one bubble per cycle that `out_busy` is high at a boundary.
- Stall: if `out_busy` is high at a boundary for N cycles, `exec` is low for exactly N cycles. The next window then starts with `k_init` and the same addresses it would have used unstalled.
- `k_fin` is at cycle v and the next window's `k_init` is at v+1 when not stalled (back-to-back windows).

## Test plan
- **Basic map:** `iw`=2, `ow`=`oh`=1, `kw`=`kh`=1, `out_busy`=0; `s_init` at t.
  - 16 consecutive `exec` cycles from t+1.
  - Window (0,0): `ia`=0,1,3,4; window (0,1): 1,2,4,5; window (1,0): 3,4,6,7; window (1,1): 4,5,7,8.
  - `wa`=0,1,2,3 repeating.
  - `k_init` at t+1, t+5, t+9, t+13; `k_fin` at t+4, t+8, t+12, t+16; `s_fin` at t+17.
- **Minimal:** all limits 0; `s_init` at t.
  - One `exec` at t+1 with `k_init`=`k_fin`=1, `ia`=0, `wa`=0; `s_fin` at t+2.
- **Back-pressure:** basic map with `out_busy`=1 in the `k_fin` cycle of window (0,0) and held for 3 cycles.
  - `exec` low for 3 cycles, then `k_init` with `ia`=1.
  - `out_busy` pulses mid-window cause no gap.
- **Start blocked:** `out_busy`=1 at `s_init`, released 2 cycles later.
  - First `exec` at t+3; `s_init` pulses during RUN are ignored (single `s_fin`).
- **Reset mid-operation:** assert `rst` during window (1,0).
  - Next cycle all outputs 0, no `s_fin`.
  - A new `s_init` then restarts at `ia`=0 with the full 16-cycle sequence.
- **Wrap:** `iw`=63, `ow`=63, `oh`=63, `kw`=`kh`=1.
  - Window (63,63) tap (1,1): `ia` = (64*64+64) mod 4096 = 64.
  - Back-to-back maps: `s_init` at `s_fin`+1 is accepted.
